// File: rtl/gpr_pkg.sv
// Shared constants and types for the multi-port general-purpose register file.
// Provides the zero/overflow register indices, default widths, the address
// type and a helper that validates the read-port count at elaboration.
package gpr_pkg;

  localparam int unsigned GPR_DATA_W = 32;
  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned GPR_ZERO   = 0;
  localparam int unsigned GPR_OF_REG = 30;
  localparam int unsigned GPR_MAX_RD = 4;

  typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

  // Legal read-port counts are 1..GPR_MAX_RD.
  function automatic bit gprNumRdOk(input int unsigned n);
    return (n >= 1) && (n <= GPR_MAX_RD);
  endfunction

endpackage

// File: rtl/gpr_rd_port.sv
// One read port of the GPR file: register mux, optional same-cycle write
// bypass and the register-0 / reset force to zero.
// Optional feature macro: GPR_BYPASS_EN (forward this cycle's writes).
// Ports:
//   rst        asynchronous active-high reset, forces outputs to zero
//   rdAddr     register index read by this port
//   regFile    current register contents
//   busyVec    current load-busy bits
//   aWr/aAddr/aData    committing port A write (already overflow-gated)
//   bWr/bAddr/bData    committing port B (load) write
//   ofWr/ofFlag        overflow-flag update of bit 0 of OF_REG
//   rdData_c   read data (combinational)
//   rdBusy_c   addressed register awaits a load (combinational)
module gpr_rd_port
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W = GPR_DATA_W,
  parameter int unsigned ADDR_W = GPR_ADDR_W,
  parameter int unsigned OF_REG = GPR_OF_REG
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] rdAddr,
  input  logic [DATA_W-1:0] regFile [2**ADDR_W],
  input  logic [(2**ADDR_W)-1:0] busyVec,
  input  logic              aWr,
  input  logic [ADDR_W-1:0] aAddr,
  input  logic [DATA_W-1:0] aData,
  input  logic              bWr,
  input  logic [ADDR_W-1:0] bAddr,
  input  logic [DATA_W-1:0] bData,
  input  logic              ofWr,
  input  logic              ofFlag,
  output logic [DATA_W-1:0] rdData_c,
  output logic              rdBusy_c
);

`ifndef GPR_BYPASS_EN
  // Write-side inputs only matter when forwarding is built in.
  logic unusedBypass;
  assign unusedBypass = ^{aWr, aAddr, aData, bWr, bAddr, bData, ofWr, ofFlag,
                          (rdAddr == ADDR_W'(OF_REG))};
`endif

  // Read mux; bypass layers apply in write-priority order (B, then A, then flag).
  always_comb begin
    rdData_c = regFile[rdAddr];
    rdBusy_c = busyVec[rdAddr];
`ifdef GPR_BYPASS_EN
    if (bWr && (bAddr == rdAddr)) begin
      rdData_c = bData;
      rdBusy_c = 1'b0;
    end
    if (aWr && (aAddr == rdAddr)) begin
      rdData_c = aData;
    end
    if (ofWr && (rdAddr == ADDR_W'(OF_REG))) begin
      rdData_c[0] = ofFlag;
    end
`endif
    if (rst || (rdAddr == ADDR_W'(GPR_ZERO))) begin
      rdData_c = '0;
      rdBusy_c = 1'b0;
    end
  end

endmodule

// File: rtl/gpr_mp.sv
// Multi-port general-purpose register file for the MIPS core.
// NUM_RD combinational read ports, an ALU writeback port (A) with
// overflow-gated commit and flag capture in bit 0 of OF_REG, a load
// writeback port (B), and a per-register busy scoreboard for loads.
// Optional feature macro: GPR_BYPASS_EN (reads see this cycle's writes).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   RdAddr/RdData/RdBusy             packed per-port read address/data/busy
//   WrEn/OFWrEn/OFFlag/WrAddr/WrData port A (ALU writeback)
//   LdWrEn/LdWrAddr/LdWrData         port B (load writeback)
//   IssueEn/IssueAddr                load issue, marks destination busy
module gpr_mp
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W = GPR_DATA_W,
  parameter int unsigned ADDR_W = GPR_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned OF_REG = GPR_OF_REG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        RdBusy,
  input  logic                     WrEn,
  input  logic                     OFWrEn,
  input  logic                     OFFlag,
  input  logic [ADDR_W-1:0]        WrAddr,
  input  logic [DATA_W-1:0]        WrData,
  input  logic                     LdWrEn,
  input  logic [ADDR_W-1:0]        LdWrAddr,
  input  logic [DATA_W-1:0]        LdWrData,
  input  logic                     IssueEn,
  input  logic [ADDR_W-1:0]        IssueAddr
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  if (!gprNumRdOk(NUM_RD)) begin : gNumRdCheck
    $error("gpr_mp: NUM_RD must be in 1..4");
  end

  logic [DATA_W-1:0] regs    [DEPTH];
  logic [DATA_W-1:0] regNext [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;
  logic              aCommit;
  logic              bCommit;

  // Port A is suppressed by a trapping overflow; r0 writes are dropped.
  assign aCommit = WrEn && !(OFWrEn && OFFlag) && (WrAddr != ADDR_W'(GPR_ZERO));
  assign bCommit = LdWrEn && (LdWrAddr != ADDR_W'(GPR_ZERO));

  // Next register image. Port A overrides port B on a collision; the
  // overflow flag owns bit 0 of OF_REG whenever OFWrEn is high, including
  // over a same-cycle load into OF_REG.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      regNext[i] = regs[i];
      if (bCommit && (LdWrAddr == ADDR_W'(i))) begin
        regNext[i] = LdWrData;
      end
      if (aCommit && (WrAddr == ADDR_W'(i))) begin
        regNext[i] = WrData;
      end
      if (OFWrEn && (ADDR_W'(i) == ADDR_W'(OF_REG))) begin
        regNext[i][0] = OFFlag;
      end
    end
    regNext[GPR_ZERO] = '0;
  end

  // Busy scoreboard: load writeback clears, issue sets, and set wins.
  always_comb begin
    busyNext = busy;
    if (LdWrEn) begin
      busyNext[LdWrAddr] = 1'b0;
    end
    if (IssueEn && (IssueAddr != ADDR_W'(GPR_ZERO))) begin
      busyNext[IssueAddr] = 1'b1;
    end
    busyNext[GPR_ZERO] = 1'b0;
  end

  // Register array and busy vector state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= regNext[i];
      end
      busy <= busyNext;
    end
  end

  // One read mux per port.
  for (genvar p = 0; p < int'(NUM_RD); p++) begin : gRdPort
    gpr_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .OF_REG (OF_REG)
    ) uRdPort (
      .rst      (rst),
      .rdAddr   (RdAddr[p*ADDR_W +: ADDR_W]),
      .regFile  (regs),
      .busyVec  (busy),
      .aWr      (aCommit),
      .aAddr    (WrAddr),
      .aData    (WrData),
      .bWr      (bCommit),
      .bAddr    (LdWrAddr),
      .bData    (LdWrData),
      .ofWr     (OFWrEn),
      .ofFlag   (OFFlag),
      .rdData_c (RdData[p*DATA_W +: DATA_W]),
      .rdBusy_c (RdBusy[p])
    );
  end

endmodule
